// File: rtl/cpu_pkg.sv
// Shared types and encodings for the 8-bit multicycle CPU controller.
package cpu_pkg;

  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned ALU_CTRL_W = 3;

  // Defined opcodes; 0xC-0xF are undefined.
  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SLT = 4'h6,
    OP_INC = 4'h7,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_JMP = 4'hA,
    OP_HLT = 4'hB
  } opcode_t;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 3'd5;

  typedef enum logic [2:0] {
    FETCH1,
    FETCH2,
    ALU,
    INC,
    LOAD,
    STORE,
    JUMP,
    HALT
  } state_t;

  // Datapath control word for one state.
  typedef struct packed {
    logic                  pc_select;
    logic                  pc_enable;
    logic                  adr_select;
    logic                  ir1_en;
    logic                  ir2_en;
    logic                  reg_select;
    logic                  wd3_select;
    logic                  reg_write;
    logic                  op1_sel;
    logic                  op2_sel;
    logic                  alu_out_en;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  mem_write;
  } ctrl_t;

  // ALU operation for a register-register opcode; anything else adds.
  function automatic logic [ALU_CTRL_W-1:0] alu_for_op(input logic [OPCODE_W-1:0] op);
    logic [ALU_CTRL_W-1:0] r_res;
    r_res = ALU_ADD;
    case (op)
      OP_ADD:  r_res = ALU_ADD;
      OP_SUB:  r_res = ALU_SUB;
      OP_AND:  r_res = ALU_AND;
      OP_OR:   r_res = ALU_OR;
      OP_XOR:  r_res = ALU_XOR;
      OP_SLT:  r_res = ALU_SLT;
      default: r_res = ALU_ADD;
    endcase
    return r_res;
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath bundle: opcode in, selects/enables/status out.
interface control_unit_if;
  import cpu_pkg::*;

  logic [OPCODE_W-1:0]   opcode;
  logic                  pcSelect;
  logic                  pcEnable;
  logic                  adrSelect;
  logic                  ir1En;
  logic                  ir2En;
  logic                  regSelect;
  logic                  wd3Select;
  logic                  regWrite;
  logic                  op1Sel;
  logic                  op2Sel;
  logic                  aluOutEn;
  logic [ALU_CTRL_W-1:0] aluControl;
  logic                  memWrite;
  logic                  instrDone;
  logic                  halted;
  logic                  illegal;

  modport master (
    input  opcode,
    output pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect, wd3Select,
           regWrite, op1Sel, op2Sel, aluOutEn, aluControl, memWrite,
           instrDone, halted, illegal
  );

  modport slave (
    output opcode,
    input  pcSelect, pcEnable, adrSelect, ir1En, ir2En, regSelect, wd3Select,
           regWrite, op1Sel, op2Sel, aluOutEn, aluControl, memWrite,
           instrDone, halted, illegal
  );

endinterface

// File: rtl/control_decode.sv
// Combinational decode of FSM state (+ opcode for ALU ops) into the control word.
module control_decode
  import cpu_pkg::*;
(
  input  state_t              i_state,
  input  logic [OPCODE_W-1:0] i_opcode,
  output ctrl_t               o_ctrl_c
);

  // Per-state control word; unlisted fields stay 0 and the ALU adds.
  always_comb begin
    o_ctrl_c             = '0;
    o_ctrl_c.alu_control = ALU_ADD;
    case (i_state)
      FETCH1: begin
        o_ctrl_c.ir1_en    = 1'b1;
        o_ctrl_c.op2_sel   = 1'b1;
        o_ctrl_c.pc_enable = 1'b1;
      end
      FETCH2: begin
        o_ctrl_c.ir2_en    = 1'b1;
        o_ctrl_c.op2_sel   = 1'b1;
        o_ctrl_c.pc_enable = 1'b1;
      end
      ALU: begin
        o_ctrl_c.reg_select  = 1'b1;
        o_ctrl_c.op1_sel     = 1'b1;
        o_ctrl_c.wd3_select  = 1'b1;
        o_ctrl_c.reg_write   = 1'b1;
        o_ctrl_c.alu_out_en  = 1'b1;
        o_ctrl_c.alu_control = alu_for_op(i_opcode);
      end
      INC: begin
        o_ctrl_c.op1_sel    = 1'b1;
        o_ctrl_c.op2_sel    = 1'b1;
        o_ctrl_c.wd3_select = 1'b1;
        o_ctrl_c.reg_write  = 1'b1;
        o_ctrl_c.alu_out_en = 1'b1;
      end
      LOAD: begin
        o_ctrl_c.adr_select = 1'b1;
        o_ctrl_c.reg_write  = 1'b1;
      end
      STORE: begin
        o_ctrl_c.adr_select = 1'b1;
        o_ctrl_c.mem_write  = 1'b1;
      end
      JUMP: begin
        o_ctrl_c.pc_select = 1'b1;
        o_ctrl_c.pc_enable = 1'b1;
      end
      default: begin
        o_ctrl_c.alu_control = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle FSM controller: two-byte fetch, one-cycle execute, retire/halt status.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b0
)(
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal;
  logic   w_illegal_next;
  logic   r_was_halt;
  logic   w_fetch2_done;
  logic   w_done;
  ctrl_t  w_ctrl;

  control_decode u_decode (
    .i_state  (r_state),
    .i_opcode (bus.opcode),
    .o_ctrl_c (w_ctrl)
  );

  // State, sticky illegal flag, and previous-cycle HALT marker for entry detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= FETCH1;
      r_illegal  <= 1'b0;
      r_was_halt <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_illegal  <= w_illegal_next;
      r_was_halt <= (r_state == HALT);
    end
  end

  // Next state; opcode only matters at the end of the second fetch.
  always_comb begin
    w_next_state   = r_state;
    w_illegal_next = r_illegal;
    w_fetch2_done  = 1'b0;
    case (r_state)
      FETCH1: w_next_state = FETCH2;
      FETCH2: begin
        case (bus.opcode)
          OP_NOP: begin
            w_next_state  = FETCH1;
            w_fetch2_done = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: w_next_state = ALU;
          OP_INC: w_next_state = INC;
          OP_LD:  w_next_state = LOAD;
          OP_ST:  w_next_state = STORE;
          OP_JMP: w_next_state = JUMP;
          OP_HLT: w_next_state = HALT;
          default: begin
            if (ILLEGAL_HALTS) begin
              w_next_state   = HALT;
              w_illegal_next = 1'b1;
            end else begin
              w_next_state  = FETCH1;
              w_fetch2_done = 1'b1;
            end
          end
        endcase
      end
      ALU, INC, LOAD, STORE, JUMP: w_next_state = FETCH1;
      HALT:    w_next_state = HALT;
      default: w_next_state = FETCH1;
    endcase
  end

  // Moore outputs; reset masks every enable and the retire pulse.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      ALU, INC, LOAD, STORE, JUMP: w_done = 1'b1;
      FETCH2:  w_done = w_fetch2_done;
      HALT:    w_done = ~r_was_halt;
      default: w_done = 1'b0;
    endcase

    bus.pcSelect   = w_ctrl.pc_select;
    bus.adrSelect  = w_ctrl.adr_select;
    bus.regSelect  = w_ctrl.reg_select;
    bus.wd3Select  = w_ctrl.wd3_select;
    bus.op1Sel     = w_ctrl.op1_sel;
    bus.op2Sel     = w_ctrl.op2_sel;
    bus.aluControl = w_ctrl.alu_control;
    bus.pcEnable   = w_ctrl.pc_enable  & ~reset;
    bus.ir1En      = w_ctrl.ir1_en     & ~reset;
    bus.ir2En      = w_ctrl.ir2_en     & ~reset;
    bus.regWrite   = w_ctrl.reg_write  & ~reset;
    bus.memWrite   = w_ctrl.mem_write  & ~reset;
    bus.aluOutEn   = w_ctrl.alu_out_en & ~reset;
    bus.instrDone  = w_done            & ~reset;
    bus.halted     = (r_state == HALT);
    bus.illegal    = r_illegal;
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench: control_unit driving a behavioural datapath with 256x8 async-read memory.
module tb_control_unit;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  logic preload;

  control_unit_if u_if ();
  control_unit_if u_if0 ();

  control_unit #(.ILLEGAL_HALTS(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // Second controller with undefined opcodes running as NOP, fed 0xD forever.
  control_unit #(.ILLEGAL_HALTS(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if0)
  );

  assign u_if0.opcode = 4'hD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model
  logic [7:0] mem [256];
  logic [7:0] init_mem [256];
  logic [7:0] rf [16];
  logic [7:0] init_rf [16];
  logic [7:0] pc, ir1, ir2, alu_out_m;
  logic [7:0] mem_adr, mem_rd, rd1, rd2, alu_a, alu_b, alu_y, pc_next, wd3;

  assign u_if.opcode = ir1[7:4];

  always_comb begin
    mem_adr = u_if.adrSelect ? ir2 : pc;
    mem_rd  = mem[mem_adr];
    rd1     = rf[u_if.regSelect ? ir2[7:4] : ir1[3:0]];
    rd2     = rf[ir2[3:0]];
    alu_a   = u_if.op1Sel ? rd1 : pc;
    alu_b   = u_if.op2Sel ? 8'h01 : rd2;
    case (u_if.aluControl)
      3'd0:    alu_y = alu_a + alu_b;
      3'd1:    alu_y = alu_a - alu_b;
      3'd2:    alu_y = alu_a & alu_b;
      3'd3:    alu_y = alu_a | alu_b;
      3'd4:    alu_y = alu_a ^ alu_b;
      3'd5:    alu_y = ($signed(alu_a) < $signed(alu_b)) ? 8'h01 : 8'h00;
      default: alu_y = 8'h00;
    endcase
    pc_next = u_if.pcSelect ? ir2 : alu_y;
    wd3     = u_if.wd3Select ? alu_y : mem_rd;
  end

  always @(posedge clk) begin
    if (reset) begin
      pc  <= 8'h00;
      ir1 <= 8'h00;
      ir2 <= 8'h00;
      if (preload) begin
        mem <= init_mem;
        rf  <= init_rf;
      end
    end else begin
      if (u_if.pcEnable) pc <= pc_next;
      if (u_if.ir1En)    ir1 <= mem_rd;
      if (u_if.ir2En)    ir2 <= mem_rd;
      if (u_if.regWrite) rf[ir1[3:0]] <= wd3;
      if (u_if.memWrite) mem[mem_adr] <= rd1;
      if (u_if.aluOutEn) alu_out_m <= alu_y;
    end
  end

  // Event counters sampled away from the active edge
  int n_memwr = 0;
  int n_done0 = 0;
  always @(negedge clk) begin
    if (u_if.memWrite)   n_memwr <= n_memwr + 1;
    if (u_if0.instrDone) n_done0 <= n_done0 + 1;
  end

  // Scoreboard: expected retire latency and PC afterwards, per instruction
  typedef struct {
    string      tag;
    int         lat;
    logic [7:0] pc;
  } exp_t;
  exp_t sb [$];

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] done_alu;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic void push(input string tag, input int lat, input logic [7:0] pcv);
    exp_t e;
    e.tag = tag;
    e.lat = lat;
    e.pc  = pcv;
    sb.push_back(e);
  endfunction

  // Run one instruction to its retire pulse and compare against the scoreboard.
  task automatic run_one();
    exp_t e;
    int   cyc;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL sb_empty: got 0 entries want >=1");
      return;
    end
    e   = sb.pop_front();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (u_if.instrDone !== 1'b1 && cyc < 20);
    done_alu = u_if.aluControl;
    check({e.tag, "_lat"}, 32'(cyc), 32'(e.lat));
    @(posedge clk);
    #1;
    check({e.tag, "_pc"}, 32'(pc), 32'(e.pc));
  endtask

  task automatic clear_init();
    for (int i = 0; i < 256; i++) init_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++)  init_rf[i]  = 8'h00;
  endtask

  // Two-cycle reset; enables must be masked while it is held.
  task automatic do_reset(input bit load);
    logic [6:0] en;
    preload = load;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    en = {u_if.pcEnable, u_if.ir1En, u_if.ir2En, u_if.regWrite,
          u_if.memWrite, u_if.aluOutEn, u_if.instrDone};
    check("rst_enables", 32'(en), 32'h0);
    reset   = 1'b0;
    preload = 1'b0;
  endtask

  initial begin
    logic [6:0] en;
    int         snap;

    reset    = 1'b1;
    preload  = 1'b0;
    done_alu = 3'd0;

    // NOP: two cycles, PC 0 -> 2
    clear_init();
    push("nop", 2, 8'h02);
    do_reset(1'b1);
    run_one();

    // SUB r3=r1-r2, INC r3, SLT r5=(r2<r1)
    clear_init();
    init_mem[0] = 8'h23; init_mem[1] = 8'h12;
    init_mem[2] = 8'h73; init_mem[3] = 8'h00;
    init_mem[4] = 8'h65; init_mem[5] = 8'h21;
    init_rf[1]  = 8'h05; init_rf[2]  = 8'h03;
    push("sub", 3, 8'h02);
    push("inc", 3, 8'h04);
    push("slt", 3, 8'h06);
    do_reset(1'b1);
    run_one();
    check("sub_aluctl", 32'(done_alu), 32'(ALU_SUB));
    check("sub_r3", 32'(rf[3]), 32'h02);
    run_one();
    check("inc_r3", 32'(rf[3]), 32'h03);
    run_one();
    check("slt_aluctl", 32'(done_alu), 32'(ALU_SLT));
    check("slt_r5", 32'(rf[5]), 32'h01);

    // LD r4,[0x80] then ST r4,[0x81]
    clear_init();
    init_mem[0] = 8'h84; init_mem[1] = 8'h80;
    init_mem[2] = 8'h94; init_mem[3] = 8'h81;
    init_mem[8'h80] = 8'hA5;
    push("ld", 3, 8'h02);
    push("st", 3, 8'h04);
    do_reset(1'b1);
    run_one();
    check("ld_r4", 32'(rf[4]), 32'hA5);
    snap = n_memwr;
    run_one();
    check("st_mem81", 32'(mem[8'h81]), 32'hA5);
    check("st_memwr_cycles", 32'(n_memwr - snap), 32'd1);

    // Jumps, JMP at 0xFE (ir2 from 0xFF), AND at 0xFF (ir2 from 0x00, PC wraps)
    clear_init();
    init_mem[8'h00] = 8'hA0; init_mem[8'h01] = 8'h10;
    init_mem[8'h10] = 8'hA0; init_mem[8'h11] = 8'hFE;
    init_mem[8'hFE] = 8'hA0; init_mem[8'hFF] = 8'h30;
    init_mem[8'h30] = 8'hA0; init_mem[8'h31] = 8'hFF;
    init_rf[0]  = 8'h3C;
    init_rf[10] = 8'hF0;
    push("jmp10", 3, 8'h10);
    push("jmpfe", 3, 8'hFE);
    push("jmp30", 3, 8'h30);
    push("jmpff", 3, 8'hFF);
    push("and_wrap", 3, 8'h01);
    do_reset(1'b1);
    run_one();
    run_one();
    run_one();
    run_one();
    run_one();
    check("and_aluctl", 32'(done_alu), 32'(ALU_AND));
    check("and_r0", 32'(rf[0]), 32'h30);

    // HLT: retire pulse on entry, then quiet for 20 cycles
    clear_init();
    init_mem[0] = 8'hB0;
    push("hlt", 3, 8'h02);
    do_reset(1'b1);
    run_one();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      en = {u_if.pcEnable, u_if.ir1En, u_if.ir2En, u_if.regWrite,
            u_if.memWrite, u_if.aluOutEn, u_if.instrDone};
      check("halt_quiet", 32'({u_if.halted, en}), 32'h80);
    end
    check("halt_not_illegal", 32'(u_if.illegal), 32'h0);
    @(posedge clk);
    #1;
    check("halt_pc_held", 32'(pc), 32'h02);

    // Undefined opcode 0xD: halts with illegal on the halting controller
    clear_init();
    init_mem[0] = 8'hD0;
    push("illegal", 3, 8'h02);
    do_reset(1'b1);
    run_one();
    check("illegal_flag", 32'(u_if.illegal), 32'h1);
    check("illegal_halted", 32'(u_if.halted), 32'h1);
    // Non-halting controller keeps retiring 0xD as a 2-cycle NOP
    snap = n_done0;
    repeat (10) @(posedge clk);
    #1;
    check("nohalt_retires", 32'(n_done0 - snap), 32'd5);
    check("nohalt_flags", 32'({u_if0.halted, u_if0.illegal}), 32'h0);

    // Reset asserted during the ALU cycle aborts the write and restarts at PC 0
    clear_init();
    init_mem[0] = 8'h23; init_mem[1] = 8'h12;
    init_rf[1]  = 8'h05; init_rf[2] = 8'h03; init_rf[3] = 8'h77;
    do_reset(1'b1);
    @(negedge clk);
    check("abort_fetch1", 32'(u_if.ir1En), 32'h1);
    @(negedge clk);
    check("abort_fetch2", 32'(u_if.ir2En), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_alu", 32'(u_if.regSelect), 32'h1);
    check("abort_masked", 32'({u_if.regWrite, u_if.aluOutEn, u_if.instrDone, u_if.pcEnable}), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_r3_kept", 32'(rf[3]), 32'h77);
    check("abort_pc0", 32'(pc), 32'h00);
    @(negedge clk);
    check("abort_restart", 32'({u_if.ir1En, u_if.ir2En}), 32'h2);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
